trace_buffer: RTL and testbench

Synthesizable, parametrised instruction-trace recorder for the multicycle core: the hardware successor to the simulation-only cycle logger. It samples per-cycle core state (PC, instruction, FSM state, register and memory write-back) into a circular buffer filtered by a capture mode, freezes on a PC-match trigger after a programmable post-trigger window, and drains the frozen records oldest-first over a valid/ready port. It sits beside the core's datapath taps and feeds a debug UART or JTAG reader.

---
 rtl/trace_buffer.sv | 171 +++++++++++++++++
 tb/tb_trace_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: circular instruction-trace recorder for the multicycle core.
// Records filtered per-cycle core state, freezes after a PC-match trigger plus
// a post-trigger window (or on force_stop), then drains records oldest-first.
//
// Read handshake: while rd_valid is high the rd_* fields hold the oldest
// record and stay stable; a record is consumed on the rising clk edge where
// rd_valid && rd_ready, and the next record (if any) is presented right after
// that edge. rd_ready is a don't-care while rd_valid is low.
module trace_buffer #(
   parameter int DEPTH   = 16,
   parameter int CYCLE_W = 16,
   parameter int PTR_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [31:0]        pc_cur,
   input  logic [31:0]        instruction,
   input  logic [4:0]         fsm_state,
   input  logic               reg_write,
   input  logic [4:0]         rd,
   input  logic [31:0]        result,
   input  logic               mem_write,
   input  logic [31:0]        memory_address,
   input  logic [31:0]        memory_data,
   input  logic [1:0]         mode,
   input  logic               arm,
   input  logic               force_stop,
   input  logic               trig_en,
   input  logic [31:0]        trig_pc,
   input  logic [PTR_W:0]     post_count,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [CYCLE_W-1:0] rd_ts,
   output logic [31:0]        rd_pc,
   output logic [31:0]        rd_instr,
   output logic [4:0]         rd_fsm,
   output logic               rd_reg_write,
   output logic [4:0]         rd_rd,
   output logic [31:0]        rd_result,
   output logic               rd_mem_write,
   output logic [31:0]        rd_addr,
   output logic [31:0]        rd_data,
   output logic [1:0]         state,
   output logic [PTR_W:0]     count,
   output logic               wrapped
);

   localparam int REC_W = CYCLE_W + 172;
   localparam logic [PTR_W:0] FULL     = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] MAX_POST = (PTR_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             cur_state, nxt_state;
   logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
   logic [PTR_W:0]     count_r, count_n;
   logic               wrapped_r, wrapped_n;
   logic [PTR_W:0]     remaining, remaining_n;
   logic [CYCLE_W-1:0] ts;
   logic               wr_en;
   logic               filt;
   logic               capturing;
   logic               q;
   logic [PTR_W:0]     post_clamped;
   logic [PTR_W-1:0]   rd_idx;
   logic [REC_W-1:0]   rec_in;
   logic [REC_W-1:0]   rd_rec;
   logic [REC_W-1:0]   mem [DEPTH];

   // Free-running timestamp, wraps silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts <= '0;
      else          ts <= ts + CYCLE_W'(1);
   end

   assign rec_in = {ts, pc_cur, instruction, fsm_state, reg_write, rd, result,
                    mem_write, memory_address, memory_data};

   // Record storage; contents are only observable through the gated read port.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rec_in;
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= IDLE;
         wr_ptr    <= '0;
         count_r   <= '0;
         wrapped_r <= 1'b0;
         remaining <= '0;
      end else begin
         cur_state <= nxt_state;
         wr_ptr    <= wr_ptr_n;
         count_r   <= count_n;
         wrapped_r <= wrapped_n;
         remaining <= remaining_n;
      end
   end

   // Capture filter, trigger/post window and drain bookkeeping.
   always_comb begin
      nxt_state   = cur_state;
      wr_ptr_n    = wr_ptr;
      count_n     = count_r;
      wrapped_n   = wrapped_r;
      remaining_n = remaining;
      wr_en       = 1'b0;
      case (mode)
         2'd0:    filt = 1'b1;
         2'd1:    filt = (fsm_state == 5'b00000);
         2'd2:    filt = (reg_write && (rd != 5'd0)) || mem_write;
         default: filt = 1'b0;
      endcase
      capturing    = (cur_state == ARMED) || (cur_state == POST);
      // The arm cycle itself is never recorded.
      q            = capturing && filt && !arm;
      post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;
      if (arm) begin
         nxt_state   = ARMED;
         wr_ptr_n    = '0;
         count_n     = '0;
         wrapped_n   = 1'b0;
         remaining_n = '0;
      end else begin
         if (q) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + PTR_W'(1);
            if (count_r == FULL) wrapped_n = 1'b1;
            else                 count_n   = count_r + (PTR_W+1)'(1);
         end
         case (cur_state)
            ARMED: begin
               if (q && trig_en && (pc_cur == trig_pc)) begin
                  remaining_n = post_clamped;
                  nxt_state   = (post_clamped == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (q) begin
                  remaining_n = remaining - (PTR_W+1)'(1);
                  if (remaining == (PTR_W+1)'(1)) nxt_state = DONE;
               end
            end
            DONE: begin
               if (rd_valid && rd_ready) count_n = count_r - (PTR_W+1)'(1);
            end
            default: ;
         endcase
         if (capturing && force_stop) nxt_state = DONE;
      end
   end

   // Oldest record sits count entries behind the write pointer.
   assign rd_idx   = wr_ptr - count_r[PTR_W-1:0];
   assign rd_valid = (cur_state == DONE) && (count_r != '0);
   assign rd_rec   = rd_valid ? mem[rd_idx] : '0;

   assign {rd_ts, rd_pc, rd_instr, rd_fsm, rd_reg_write, rd_rd, rd_result,
           rd_mem_write, rd_addr, rd_data} = rd_rec;

   assign state   = cur_state;
   assign count   = count_r;
   assign wrapped = wrapped_r;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: randomized stimulus against a queue-based reference model
// of the trace recorder, plus directed capture/drain/reset scenarios.
module tb_trace_buffer;

   localparam int DEPTH   = 16;
   localparam int CYCLE_W = 16;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int REC_W   = CYCLE_W + 172;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [31:0]        pc_cur = '0, instruction = '0, result = '0;
   logic [31:0]        memory_address = '0, memory_data = '0, trig_pc = '0;
   logic [4:0]         fsm_state = '0, rd = '0;
   logic               reg_write = 1'b0, mem_write = 1'b0;
   logic [1:0]         mode = '0;
   logic               arm = 1'b0, force_stop = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;
   logic [PTR_W:0]     post_count = '0;
   logic               rd_valid, rd_reg_write, rd_mem_write, wrapped;
   logic [CYCLE_W-1:0] rd_ts;
   logic [31:0]        rd_pc, rd_instr, rd_result, rd_addr, rd_data;
   logic [4:0]         rd_fsm, rd_rd;
   logic [1:0]         state;
   logic [PTR_W:0]     count;
   logic [REC_W-1:0]   got_rec;

   // model state
   logic [REC_W-1:0]   exp_q[$];
   int                 m_state;
   int                 m_rem;
   logic               m_wrapped;
   logic [CYCLE_W-1:0] m_ts;

   int n_vec = 0;
   int n_err = 0;

   trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) dut (
      .clk(clk), .reset_n(reset_n), .pc_cur(pc_cur), .instruction(instruction),
      .fsm_state(fsm_state), .reg_write(reg_write), .rd(rd), .result(result),
      .mem_write(mem_write), .memory_address(memory_address), .memory_data(memory_data),
      .mode(mode), .arm(arm), .force_stop(force_stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .post_count(post_count), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_ts(rd_ts), .rd_pc(rd_pc), .rd_instr(rd_instr),
      .rd_fsm(rd_fsm), .rd_reg_write(rd_reg_write), .rd_rd(rd_rd),
      .rd_result(rd_result), .rd_mem_write(rd_mem_write), .rd_addr(rd_addr),
      .rd_data(rd_data), .state(state), .count(count), .wrapped(wrapped)
   );

   // clock
   always #5 clk = ~clk;

   assign got_rec = {rd_ts, rd_pc, rd_instr, rd_fsm, rd_reg_write, rd_rd,
                     rd_result, rd_mem_write, rd_addr, rd_data};

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_rem     = 0;
      m_wrapped = 1'b0;
      m_ts      = '0;
      exp_q.delete();
   endtask

   task automatic rand_inputs();
      pc_cur         = $urandom;
      instruction    = $urandom;
      fsm_state      = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      reg_write      = 1'($urandom_range(0, 1));
      rd             = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      result         = $urandom;
      mem_write      = ($urandom_range(0, 3) == 0);
      memory_address = $urandom;
      memory_data    = $urandom;
      rd_ready       = 1'($urandom_range(0, 1));
      arm            = 1'b0;
      force_stop     = 1'b0;
   endtask

   // Apply current inputs for one clock, advance the model, compare outputs.
   task automatic step();
      logic             filt, q;
      logic [REC_W-1:0] rec, exp_rec;
      int               post;
      case (mode)
         2'd0:    filt = 1'b1;
         2'd1:    filt = (fsm_state == 5'd0);
         2'd2:    filt = (reg_write && rd != 5'd0) || mem_write;
         default: filt = 1'b0;
      endcase
      q   = (m_state == 1 || m_state == 2) && filt && !arm;
      rec = {m_ts, pc_cur, instruction, fsm_state, reg_write, rd, result,
             mem_write, memory_address, memory_data};
      if (arm) begin
         m_state   = 1;
         m_wrapped = 1'b0;
         exp_q.delete();
      end else if (m_state == 3) begin
         if (exp_q.size() > 0 && rd_ready) void'(exp_q.pop_front());
      end else if (m_state != 0) begin
         if (q) begin
            exp_q.push_back(rec);
            if (exp_q.size() > DEPTH) begin
               void'(exp_q.pop_front());
               m_wrapped = 1'b1;
            end
         end
         if (m_state == 1 && q && trig_en && pc_cur == trig_pc) begin
            post    = int'(post_count);
            m_rem   = (post > DEPTH - 1) ? DEPTH - 1 : post;
            m_state = (m_rem == 0) ? 3 : 2;
         end else if (m_state == 2 && q) begin
            m_rem--;
            if (m_rem == 0) m_state = 3;
         end
         if (force_stop) m_state = 3;
      end
      m_ts = m_ts + 1'b1;
      @(posedge clk);
      #1;
      exp_rec = (m_state == 3 && exp_q.size() > 0) ? exp_q[0] : '0;
      check("state", state, m_state[1:0]);
      check("count", count, exp_q.size());
      check("wrapped", wrapped, m_wrapped);
      check("rd_valid", rd_valid, (m_state == 3 && exp_q.size() > 0));
      check("rd_rec", got_rec, exp_rec);
   endtask

   task automatic do_arm();
      rand_inputs();
      arm = 1'b1;
      step();
   endtask

   task automatic drain(input int cycles, input bit always_ready);
      for (int i = 0; i < cycles; i++) begin
         rand_inputs();
         if (always_ready) rd_ready = 1'b1;
         step();
      end
   endtask

   logic [CYCLE_W-1:0] ts29;
   int                 pattern[5] = '{1, 0, 1, 1, 1};

   initial begin
      // reset
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state, 2'd0);
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_rec", got_rec, '0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin rand_inputs(); step(); end

      // trigger on cycle 5, post 3 -> 9 records
      mode = 2'd0; trig_en = 1'b1; trig_pc = 32'hCAFE_0000; post_count = 5'd3;
      do_arm();
      for (int i = 0; i < 9; i++) begin
         rand_inputs();
         if (i == 5) pc_cur = trig_pc;
         step();
      end
      check("s1_state", state, 2'd3);
      check("s1_count", count, 9);
      check("s1_wrapped", wrapped, 1'b0);
      drain(12, 1'b1);

      // trigger on cycle 40, post 4 -> wrap, oldest is cycle 29
      post_count = 5'd4; trig_pc = 32'h0000_4040;
      do_arm();
      ts29 = '0;
      for (int i = 0; i < 45; i++) begin
         rand_inputs();
         if (i == 40) pc_cur = trig_pc;
         if (i == 29) ts29 = m_ts;
         step();
      end
      check("s2_count", count, 16);
      check("s2_wrapped", wrapped, 1'b1);
      check("s2_first_ts", rd_ts, ts29);
      drain(40, 1'b0);

      // mode 2: three write-back events, one with rd=0, then force_stop
      mode = 2'd2; trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 16; i++) begin
         rand_inputs();
         reg_write = 1'b0; mem_write = 1'b0;
         if (i == 3) begin reg_write = 1'b1; rd = 5'd0; end
         if (i == 7) begin reg_write = 1'b1; rd = 5'd5; end
         if (i == 12) mem_write = 1'b1;
         if (i == 15) force_stop = 1'b1;
         step();
      end
      check("s3_count", count, 2);
      check("s3_first_rd", rd_rd, 5'd5);
      drain(4, 1'b1);

      // post_count 31 clamps to 15: trigger record is oldest
      mode = 2'd0; trig_en = 1'b1; trig_pc = 32'h0000_3131; post_count = 5'd31;
      do_arm();
      for (int i = 0; i < 36; i++) begin
         rand_inputs();
         if (i == 20) pc_cur = trig_pc;
         step();
      end
      check("s4_state", state, 2'd3);
      check("s4_count", count, 16);
      check("s4_oldest_pc", rd_pc, trig_pc);
      drain(20, 1'b1);

      // count 4, rd_ready pattern 1,0,1,1,1
      trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         if (i == 3) force_stop = 1'b1;
         step();
      end
      check("s5_count", count, 4);
      for (int i = 0; i < 5; i++) begin
         rand_inputs();
         rd_ready = 1'(pattern[i]);
         step();
      end
      check("s5_empty_count", count, 0);
      check("s5_empty_valid", rd_valid, 1'b0);
      rand_inputs();
      arm = 1'b1; force_stop = 1'b1;
      step();
      check("s5_arm_state", state, 2'd1);
      check("s5_arm_count", count, 0);

      // asynchronous reset during POST with 7 records
      trig_en = 1'b1; trig_pc = 32'h0000_7777; post_count = 5'd10;
      do_arm();
      for (int i = 0; i < 7; i++) begin
         rand_inputs();
         if (i == 4) pc_cur = trig_pc;
         step();
      end
      check("s6_pre_state", state, 2'd2);
      check("s6_pre_count", count, 7);
      #2 reset_n = 1'b0;
      #1;
      check("s6_rst_state", state, 2'd0);
      check("s6_rst_count", count, 0);
      check("s6_rst_valid", rd_valid, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin rand_inputs(); step(); end

      // random soak
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) begin
            arm        = 1'b1;
            trig_en    = 1'($urandom_range(0, 3) != 0);
            trig_pc    = $urandom;
            post_count = 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 79) == 0) force_stop = 1'b1;
         if ($urandom_range(0, 19) == 0) pc_cur = trig_pc;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
